alu_req_arbiter: RTL and testbench

ALU_REQ_ARBITER -- requirements
Module: alu_req_arbiter

---
 rtl/alu_req_arbiter.sv | 233 +++++++++++++++++++++++
 tb/tb_alu_req_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_arbiter.sv
// -----------------------------------------------------------------------------
// alu_req_arbiter
//
// Shares a single ALU between two requesters. Jobs are accepted one at a
// time with round-robin arbitration, launched with a one-cycle alu_start
// pulse, and completed with a one-cycle response strobe that carries the
// owner id, the ALU result and an error flag. Opcodes 5'b11000 and above are
// rejected without touching the ALU.
//
// Optional feature (compile-time macro):
//   ALU_TIMEOUT_EN  when defined, a watchdog aborts a job after TIMEOUT
//                   cycles in WAIT without alu_done and answers with
//                   rsp_err=1, rsp_data=8'hFF. When undefined, WAIT lasts
//                   until alu_done or rst.
//
// Parameters:
//   TIMEOUT      WAIT cycles before the watchdog fires (ALU_TIMEOUT_EN only)
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          synchronous active-high reset
//   req0_valid   requester 0 has a job pending
//   req0_ready   requester 0 job accepted this cycle (combinational)
//   req0_op      requester 0 opcode, 5 bits
//   req0_a/b     requester 0 operands, 4 bits each
//   req1_*       same set for requester 1
//   alu_start    one-cycle launch pulse to the ALU
//   alu_op/a/b   registered job fields presented to the ALU
//   alu_done     ALU result valid (only looked at in WAIT)
//   alu_result   ALU result, 8 bits
//   rsp_valid    one-cycle response strobe, no backpressure
//   rsp_id       owner of the response (0 or 1)
//   rsp_data     response data, 8 bits
//   rsp_err      response error flag
//   busy         high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module alu_req_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,

  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [4:0] req0_op,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,

  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [4:0] req1_op,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,

  output logic       alu_start,
  output logic [4:0] alu_op,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  input  logic       alu_done,
  input  logic [7:0] alu_result,

  output logic       rsp_valid,
  output logic       rsp_id,
  output logic [7:0] rsp_data,
  output logic       rsp_err,

  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // First opcode value that the ALU does not implement.
  localparam logic [4:0] OP_INVALID_MIN = 5'b11000;

  if (TIMEOUT < 1) begin : g_timeout_check
    $error("alu_req_arbiter: TIMEOUT must be at least 1");
  end

  state_t     state;
  logic       last_grant;   // requester that completed the previous job
  logic       owner;        // requester that owns the job in flight

  logic       accept;
  logic       grant_id;
  logic [4:0] sel_op;
  logic [3:0] sel_a;
  logic [3:0] sel_b;

`ifdef ALU_TIMEOUT_EN
  localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] wait_cnt;   // cycles already spent in WAIT
`endif

  // ---------------------------------------------------------------------------
  // Arbitration and operand select.
  // A lone valid requester always wins; on a tie the one that did not win
  // last time gets the grant.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    grant_id = 1'b0;
    sel_op   = '0;
    sel_a    = '0;
    sel_b    = '0;

    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant;
    end else begin
      grant_id = req1_valid;
    end

    if (grant_id) begin
      sel_op = req1_op;
      sel_a  = req1_a;
      sel_b  = req1_b;
    end else begin
      sel_op = req0_op;
      sel_a  = req0_a;
      sel_b  = req0_b;
    end
  end

  // Ready is combinational so the requester sees acceptance in the same cycle
  // it presents the job; it is suppressed while reset is asserted.
  assign accept     = !rst && (state == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = accept && !grant_id;
  assign req1_ready = accept &&  grant_id;

  assign busy = (state != IDLE);

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before this edge, independent of statement order.
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;   // req0 wins the first tie after reset
      owner      <= 1'b0;
      alu_start  <= 1'b0;
      alu_op     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
`ifdef ALU_TIMEOUT_EN
      wait_cnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            owner  <= grant_id;
            alu_op <= sel_op;
            alu_a  <= sel_a;
            alu_b  <= sel_b;
            if (sel_op >= OP_INVALID_MIN) begin
              // Unsupported opcode: answer directly, the ALU never starts.
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_id    <= grant_id;
              rsp_data  <= 8'h00;
              rsp_err   <= 1'b1;
            end else begin
              state     <= ISSUE;
              alu_start <= 1'b1;
            end
          end
        end

        ISSUE: begin
          // alu_done seen during ISSUE belongs to nobody and is dropped.
          alu_start <= 1'b0;
          state     <= WAIT;
`ifdef ALU_TIMEOUT_EN
          wait_cnt  <= '0;
`endif
        end

        WAIT: begin
          if (alu_done) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_id    <= owner;
            rsp_data  <= alu_result;
            rsp_err   <= 1'b0;
          end
`ifdef ALU_TIMEOUT_EN
          else if (wait_cnt == CNT_LAST) begin
            // Watchdog: this was the last allowed WAIT cycle.
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_id    <= owner;
            rsp_data  <= 8'hFF;
            rsp_err   <= 1'b1;
          end else begin
            wait_cnt  <= wait_cnt + 1'b1;
          end
`endif
        end

        RESP: begin
          // Response strobe lasts one cycle; outputs return to zero in IDLE.
          state      <= IDLE;
          last_grant <= owner;
          rsp_valid  <= 1'b0;
          rsp_id     <= 1'b0;
          rsp_data   <= '0;
          rsp_err    <= 1'b0;
          alu_op     <= '0;
          alu_a      <= '0;
          alu_b      <= '0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_req_arbiter
//
// Directed self-checking bench for alu_req_arbiter. A small ALU model answers
// alu_start after a programmable delay; expected responses are pushed to a
// scoreboard queue when a job is driven and compared when rsp_valid appears.
// Inputs change 1 time unit after the rising edge, outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_alu_req_arbiter;

  localparam int TIMEOUT = 15;

  typedef struct packed {
    logic       id;
    logic [7:0] data;
    logic       err;
  } rsp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [4:0] req0_op, req1_op;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic       alu_start;
  logic [4:0] alu_op;
  logic [3:0] alu_a, alu_b;
  logic       alu_done;
  logic [7:0] alu_result;
  logic       rsp_valid, rsp_id, rsp_err, busy;
  logic [7:0] rsp_data;

  // ALU model and direct-injection knobs
  logic       model_en    = 1'b0;
  int         model_delay = 1;
  int         mdl_cnt     = 0;
  logic       model_done  = 1'b0;
  logic [7:0] model_res   = 8'h00;
  logic       extra_done  = 1'b0;
  logic [7:0] extra_res   = 8'h00;

  // Monitor state
  int         start_count = 0;
  int         rsp_count   = 0;
  logic       dual_ready  = 1'b0;
  logic       grant_q[$];

  rsp_t       sb[$];
  int         checks   = 0;
  int         failures = 0;
  logic       rr_last;

  always #5 clk = ~clk;

  assign alu_done   = model_done | extra_done;
  assign alu_result = extra_done ? extra_res : model_res;

  alu_req_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .alu_start  (alu_start),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_done   (alu_done),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  // Reference ALU: op 01011 adds, everything else packs op and a^b.
  function automatic logic [7:0] alu_fn(input logic [4:0] op,
                                        input logic [3:0] a,
                                        input logic [3:0] b);
    if (op == 5'b01011) return 8'(a) + 8'(b);
    return {op[3:0], a ^ b};
  endfunction

  // Round-robin reference: lone requester wins, tie goes to the one not last.
  function automatic logic rr_pick(input logic v0, input logic v1, input logic last);
    if (v0 && v1) return ~last;
    return v1;
  endfunction

  // ALU model: done pulses model_delay cycles after the start cycle.
  always @(negedge clk) begin
    model_done = 1'b0;
    if (mdl_cnt > 0) begin
      mdl_cnt = mdl_cnt - 1;
      if (mdl_cnt == 0) model_done = 1'b1;
    end
    if (alu_start && model_en) begin
      mdl_cnt   = model_delay;
      model_res = alu_fn(alu_op, alu_a, alu_b);
    end
  end

  // Monitor: grants, start pulses, responses, illegal double ready.
  always @(negedge clk) begin
    if (req0_ready && req1_ready) dual_ready = 1'b1;
    if (req0_ready) grant_q.push_back(1'b0);
    if (req1_ready) grant_q.push_back(1'b1);
    if (alu_start)  start_count = start_count + 1;
    if (rsp_valid)  rsp_count   = rsp_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for rsp_valid, compares it against the scoreboard head,
  // returns the number of cycles waited and leaves time at the next edge+1.
  task automatic wait_rsp(input string tag, input int bound, output int lat);
    rsp_t exp;
    lat = 0;
    @(negedge clk);
    while (rsp_valid !== 1'b1 && lat < bound) begin
      tick();
      @(negedge clk);
      lat++;
    end
    checks++;
    assert (rsp_valid === 1'b1) else begin
      failures++;
      $error("FAIL %s_seen observed=%0b expected=1", tag, rsp_valid);
    end
    if (rsp_valid === 1'b1) begin
      checks++;
      assert (sb.size() > 0) else begin
        failures++;
        $error("FAIL %s_sb_empty observed=0 expected=1", tag);
      end
      if (sb.size() > 0) begin
        exp = sb.pop_front();
        check({tag, "_id"},   32'(rsp_id),   32'(exp.id));
        check({tag, "_data"}, 32'(rsp_data), 32'(exp.data));
        check({tag, "_err"},  32'(rsp_err),  32'(exp.err));
        rr_last = exp.id;
      end
    end
    tick();
  endtask

  function automatic logic [27:0] all_outputs();
    return {req0_ready, req1_ready, alu_start, alu_op, alu_a, alu_b,
            rsp_valid, rsp_id, rsp_data, rsp_err, busy};
  endfunction

  initial begin
    int   lat;
    int   base;
    int   snap;
    int   bad;
    logic g;
    logic exp_ids[4];

    rst        = 1'b1;
    req0_valid = 1'b1;   // ready must stay low while reset is held
    req1_valid = 1'b0;
    req0_op = 5'd0; req0_a = 4'd0; req0_b = 4'd0;
    req1_op = 5'd0; req1_a = 4'd0; req1_b = 4'd0;
    rr_last = 1'b1;

    // ---- Reset state ----
    tick();
    tick();
    @(negedge clk);
    check("reset_outputs", 32'(all_outputs()), 32'd0);
    tick();
    rst        = 1'b0;
    req0_valid = 1'b0;

    // ---- A: req0 op=01011 a=9 b=7, ALU answers 2 cycles after start ----
    model_en = 1'b1; model_delay = 2;
    req0_valid = 1'b1; req0_op = 5'b01011; req0_a = 4'd9; req0_b = 4'd7;
    sb.push_back('{id: 1'b0, data: alu_fn(5'b01011, 4'd9, 4'd7), err: 1'b0});
    @(negedge clk);
    check("a_ready", 32'({req0_ready, req1_ready}), 32'b10);
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    check("a_issue", 32'({alu_start, busy, alu_op, alu_a, alu_b}),
          32'({1'b1, 1'b1, 5'b01011, 4'd9, 4'd7}));
    tick();
    wait_rsp("a_rsp", 20, lat);
    check("a_latency", 32'(lat), 32'd2);
    @(negedge clk);
    check("a_after_rsp", 32'({rsp_valid, busy, alu_start}), 32'd0);
    check("a_starts", 32'(start_count), 32'd1);
    tick();

    // ---- B: alu_done during ISSUE only is ignored ----
    model_en = 1'b0;
    req1_valid = 1'b1; req1_op = 5'b00010; req1_a = 4'd3; req1_b = 4'd5;
    @(negedge clk);
    check("b_ready", 32'({req0_ready, req1_ready}), 32'b01);
    tick();
    req1_valid = 1'b0;
    extra_done = 1'b1; extra_res = 8'h5A;   // lands in ISSUE
    @(negedge clk);
    check("b_issue_start", 32'(alu_start), 32'd1);
    tick();
    extra_done = 1'b0;
    snap = rsp_count;
    repeat (3) tick();
    @(negedge clk);
    check("b_still_wait", 32'({busy, rsp_valid}), 32'b10);
    tick();
    check("b_no_rsp", 32'(rsp_count - snap), 32'd0);
    extra_done = 1'b1; extra_res = 8'hC3;
    sb.push_back('{id: 1'b1, data: 8'hC3, err: 1'b0});
    wait_rsp("b_rsp", 20, lat);
    extra_done = 1'b0;
    check("b_latency", 32'(lat), 32'd1);

    // ---- C: both valid continuously, four jobs alternate ----
    model_en = 1'b1; model_delay = 1;
    base = grant_q.size();
    req0_valid = 1'b1; req0_op = 5'b00001; req0_a = 4'd2; req0_b = 4'd4;
    req1_valid = 1'b1; req1_op = 5'b00100; req1_a = 4'd6; req1_b = 4'd1;
    g = rr_last;
    for (int i = 0; i < 4; i++) begin
      g = rr_pick(1'b1, 1'b1, g);
      exp_ids[i] = g;
      if (g) sb.push_back('{id: 1'b1, data: alu_fn(req1_op, req1_a, req1_b), err: 1'b0});
      else   sb.push_back('{id: 1'b0, data: alu_fn(req0_op, req0_a, req0_b), err: 1'b0});
    end
    for (int i = 0; i < 4; i++) wait_rsp($sformatf("c_rsp%0d", i), 20, lat);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("c_grant_count", 32'(grant_q.size() - base), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (base + i < grant_q.size())
        check($sformatf("c_grant%0d", i), 32'(grant_q[base + i]), 32'(exp_ids[i]));
    end
    check("c_dual_ready", 32'(dual_ready), 32'd0);

    // ---- D: invalid op from req1 answers at once, no ALU start ----
    snap = start_count;
    req1_valid = 1'b1; req1_op = 5'b11000; req1_a = 4'd1; req1_b = 4'd2;
    sb.push_back('{id: 1'b1, data: 8'h00, err: 1'b1});
    @(negedge clk);
    check("d_ready", 32'({req0_ready, req1_ready}), 32'b01);
    tick();
    wait_rsp("d_rsp", 20, lat);
    req1_valid = 1'b0;
    check("d_latency", 32'(lat), 32'd0);
    check("d_no_start", 32'(start_count - snap), 32'd0);

    // ---- E: ALU never answers ----
    model_en = 1'b0;
    req0_valid = 1'b1; req0_op = 5'b00011; req0_a = 4'd1; req0_b = 4'd1;
    @(negedge clk);
    check("e_ready", 32'({req0_ready, req1_ready}), 32'b10);
    tick();
    req0_valid = 1'b0;
`ifdef ALU_TIMEOUT_EN
    sb.push_back('{id: 1'b0, data: 8'hFF, err: 1'b1});
    wait_rsp("e_timeout", 40, lat);
    check("e_timeout_latency", 32'(lat), 32'(TIMEOUT + 1));
    @(negedge clk);
    check("e_idle_after", 32'(busy), 32'd0);
    tick();
`else
    snap = rsp_count;
    bad  = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy !== 1'b1 || rsp_valid !== 1'b0) bad++;
      tick();
    end
    check("e_hang_busy", 32'(bad), 32'd0);
    check("e_hang_no_rsp", 32'(rsp_count - snap), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rr_last = 1'b1;
`endif

    // ---- F: reset in WAIT, late alu_done afterwards ----
    model_en = 1'b1; model_delay = 4;
    req1_valid = 1'b1; req1_op = 5'b00101; req1_a = 4'd4; req1_b = 4'd4;
    tick();
    req1_valid = 1'b0;      // now in ISSUE
    tick();                 // WAIT
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rr_last = 1'b1;
    snap = rsp_count;
    @(negedge clk);
    check("f_outputs_zero", 32'(all_outputs()), 32'd0);
    bad = 0;
    for (int i = 0; i < 5; i++) begin   // covers the model's late alu_done
      tick();
      @(negedge clk);
      if (busy !== 1'b0 || rsp_valid !== 1'b0) bad++;
    end
    tick();
    check("f_stays_idle", 32'(bad), 32'd0);
    check("f_no_rsp", 32'(rsp_count - snap), 32'd0);

    // ---- G: first tie after reset goes to req0, minimum latency ----
    model_delay = 1;
    req0_valid = 1'b1; req0_op = 5'b00110; req0_a = 4'd5; req0_b = 4'd3;
    req1_valid = 1'b1; req1_op = 5'b00111; req1_a = 4'd1; req1_b = 4'd1;
    g = rr_pick(1'b1, 1'b1, rr_last);
    sb.push_back('{id: g, data: g ? alu_fn(5'b00111, 4'd1, 4'd1)
                                  : alu_fn(5'b00110, 4'd5, 4'd3), err: 1'b0});
    @(negedge clk);
    check("g_ready", 32'({req0_ready, req1_ready}), 32'b10);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_rsp("g_rsp", 20, lat);
    check("g_latency", 32'(lat), 32'd2);

    check("sb_empty", 32'(sb.size()), 32'd0);
    check("no_dual_ready", 32'(dual_ready), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
